encoding_block: RTL and testbench
=================================

Name: encoding_block

Overview:
- Transmit-side counterpart of the lane decoder.
- Accepts one byte per lane per enc_clk cycle from the lane-distribution path and assembles full encoded blocks per lane:
  - GEN2: 64b/66b
  - GEN3: 128b/132b
  - GEN4: single-byte pass-through
- Each block gets the correct sync header from data_os, then is presented in parallel to the serializer with a one-cycle valid strobe.
- Bit placement is exactly the inverse of the receive decoder, so a TX-to-RX loopback is transparent.

Parameters:
- BLOCK_W, 132, width of each encoded lane output bus.
- HDR_GEN2_DATA, 2'b01, GEN2 sync header for data blocks.
- HDR_GEN2_OS, 2'b10, GEN2 sync header for ordered-set blocks.
- HDR_GEN3_DATA, 4'b0101, GEN3 sync header for data blocks.
- HDR_GEN3_OS, 4'b1010, GEN3 sync header for ordered-set blocks.

Ports:
- enc_clk  in  1  single clock for the block.
- rst  in  1  reset; synchronous, active-high.
- enable_enc  in  1  byte-valid/enable; each cycle it is high, one byte per lane is consumed.
- gen_speed  in  2  00=GEN4, 01=GEN3, 10=GEN2, 11=reserved.
- data_os  in  1  block type: 1=ordered set, 0=data; sampled only on byte 0 of a block.
- lane_0_tx  in  8  lane 0 input byte.
- lane_1_tx  in  8  lane 1 input byte.
- lane_0_tx_enc  out  BLOCK_W  lane 0 encoded block.
- lane_1_tx_enc  out  BLOCK_W  lane 1 encoded block.
- enc_valid  out  1  one-cycle strobe: lane_x_tx_enc holds a new complete block.
- block_start  out  1  high in the cycle byte 0 of a block is consumed.

Behaviour:
- Reset (rst=1 at posedge enc_clk): all outputs 0; byte counter 0; assembly buffers 0; latched header 0; latched speed = gen_speed.
- Blocks per speed (max_byte = last byte index):
  - GEN2: max_byte=7 (8 bytes).
  - GEN3: max_byte=15 (16 bytes).
  - GEN4: max_byte=0 (1 byte per block).
  - 11: no bytes consumed, counter held at 0, enc_valid=0.
- Byte counter:
  - Increments on each cycle with enable_enc=1.
  - Wraps to 0 after max_byte.
  - enable_enc=0 forces counter to 0 and discards any partial block. Outputs hold their last value and enc_valid=0.
- Byte 0 cycle: block_start=1; header latched from data_os; speed latched from gen_speed.
- Speed change mid-block: if gen_speed differs from the latched speed while enable_enc=1 and counter≠0, the partial block is discarded. The current byte is treated as byte 0 of a new block at the new speed, with block_start=1.
- Byte placement (byte k = k-th consumed byte of the block):
  - GEN2: bits [1:0]=header; byte k at [8k+9 : 8k+2]; bits [131:66]=0.
  - GEN3: bits [3:0]=header; byte k at [8k+11 : 8k+4].
  - GEN4: byte 0 at [7:0]; bits [131:8]=0; no header.
- Output timing:
  - When byte max_byte is consumed at posedge N, the full block is registered on both lanes and enc_valid=1 in the cycle following edge N.
  - Latency: 1 cycle from last byte to output.
  - Back-to-back blocks are supported with no gap: byte 0 of the next block may be consumed in the same cycle the previous block's enc_valid is high.
- Output stability: lane_x_tx_enc changes only when enc_valid is asserted. Unused upper bits are always 0.
- Lane symmetry: both lanes share counter, header and strobe; they must be bit-identical when inputs are identical.
- GEN4: enc_valid=1 every cycle enable_enc was high on the previous edge.
- Reset mid-block: rst wins over all other inputs; the partial block is lost and no enc_valid is produced for it.

Test Plan:
- GEN2 data:
  - Stimulus: rst, gen_speed=10, data_os=0, enable_enc=1, lane_0 bytes 0x01..0x08, lane_1 bytes 0x11..0x18.
  - Response: enc_valid pulses one cycle after byte 8; lane_0_tx_enc[1:0]=01, [9:2]=0x01, [65:58]=0x08, [131:66]=0; lane_1 [9:2]=0x11.
- GEN3 ordered set:
  - Stimulus: gen_speed=01, data_os=1 at byte 0, bytes 0xA0..0xAF.
  - Response: [3:0]=1010, [11:4]=0xA0, [131:124]=0xAF; exactly one enc_valid per 16 cycles over 3 back-to-back blocks; block_start every 16th cycle.
- GEN4:
  - Stimulus: gen_speed=00, bytes 0x5A, 0xC3 on consecutive cycles.
  - Response: enc_valid high on each following cycle; [7:0]=0x5A then 0xC3; [131:8]=0.
- Abort on disable:
  - Stimulus: GEN2, 4 bytes, enable_enc=0 for 2 cycles, then 8 new bytes 0x21..0x28.
  - Response: no enc_valid for the aborted bytes; next block [9:2]=0x21.
- Speed change and reset mid-block:
  - Stimulus A: 5 GEN3 bytes, then gen_speed→10.
  - Response A: block_start on the switch cycle; GEN2 block emitted after 8 bytes with no GEN3 output.
  - Stimulus B: rst asserted after byte 3.
  - Response B: all outputs 0; no enc_valid.
- Header sampling:
  - Stimulus: toggle data_os on bytes 1..7 of a GEN2 block that started with data_os=0.
  - Response: header remains 01.

Source files
------------

// File: rtl/encoding_block.sv
// encoding_block
//   Transmit-side block assembler. Each enc_clk cycle with enable_enc high
//   consumes one byte per lane. It builds a GEN2 64b/66b block, a GEN3
//   128b/132b block or a GEN4 single-byte block. The block is then presented
//   on both lanes with a one-cycle enc_valid strobe. Bit placement is the
//   exact inverse of the lane decoder.
//
// Ports
//   enc_clk        clock
//   rst            synchronous, active-high reset
//   enable_enc     byte valid; low aborts any partial block
//   gen_speed      00=GEN4, 01=GEN3, 10=GEN2, 11=reserved (nothing consumed)
//   data_os        block type, sampled on byte 0 only (1=ordered set)
//   lane_0_tx      lane 0 input byte
//   lane_1_tx      lane 1 input byte
//   lane_0_tx_enc  lane 0 encoded block
//   lane_1_tx_enc  lane 1 encoded block
//   enc_valid      one-cycle strobe: a new complete block is on the lane outputs
//   block_start    combinational, high in the cycle byte 0 of a block is consumed
module encoding_block #(
  parameter int unsigned BLOCK_W       = 132,
  parameter logic [1:0]  HDR_GEN2_DATA = 2'b01,
  parameter logic [1:0]  HDR_GEN2_OS   = 2'b10,
  parameter logic [3:0]  HDR_GEN3_DATA = 4'b0101,
  parameter logic [3:0]  HDR_GEN3_OS   = 4'b1010
) (
  input  logic               enc_clk,
  input  logic               rst,
  input  logic               enable_enc,
  input  logic [1:0]         gen_speed,
  input  logic               data_os,
  input  logic [7:0]         lane_0_tx,
  input  logic [7:0]         lane_1_tx,
  output logic [BLOCK_W-1:0] lane_0_tx_enc,
  output logic [BLOCK_W-1:0] lane_1_tx_enc,
  output logic               enc_valid,
  output logic               block_start
);

  typedef enum logic [1:0] {
    SPD_GEN4 = 2'b00,
    SPD_GEN3 = 2'b01,
    SPD_GEN2 = 2'b10,
    SPD_RSVD = 2'b11
  } speed_t;

  speed_t             spd_in;
  speed_t             spd_q;
  logic [3:0]         cnt_q;
  logic               hdr_q;
  logic [BLOCK_W-1:0] buf0_q;
  logic [BLOCK_W-1:0] buf1_q;

  logic               consume;
  logic               start;
  logic               os_sel;
  logic               last;
  logic [3:0]         idx;
  logic [3:0]         max_byte;
  logic [7:0]         bpos;
  logic [BLOCK_W-1:0] asm0;
  logic [BLOCK_W-1:0] asm1;

  assign spd_in = speed_t'(gen_speed);

  // A new block begins on byte 0, or on any byte whose speed differs from
  // the speed latched at the start of the partial block (that block is dropped).
  always_comb begin
    consume  = enable_enc && (spd_in != SPD_RSVD);
    start    = consume && ((cnt_q == 4'd0) || (spd_in != spd_q));
    idx      = start ? 4'd0 : cnt_q;
    os_sel   = start ? data_os : hdr_q;
    bpos     = {1'b0, idx, 3'b000};
    case (spd_in)
      SPD_GEN2: max_byte = 4'd7;
      SPD_GEN3: max_byte = 4'd15;
      default:  max_byte = 4'd0;
    endcase
    last     = (idx == max_byte);
    asm0     = start ? '0 : buf0_q;
    asm1     = start ? '0 : buf1_q;
    case (spd_in)
      SPD_GEN2: begin
        asm0[1:0] = os_sel ? HDR_GEN2_OS : HDR_GEN2_DATA;
        asm1[1:0] = os_sel ? HDR_GEN2_OS : HDR_GEN2_DATA;
        asm0[bpos + 8'd2 +: 8] = lane_0_tx;
        asm1[bpos + 8'd2 +: 8] = lane_1_tx;
      end
      SPD_GEN3: begin
        asm0[3:0] = os_sel ? HDR_GEN3_OS : HDR_GEN3_DATA;
        asm1[3:0] = os_sel ? HDR_GEN3_OS : HDR_GEN3_DATA;
        asm0[bpos + 8'd4 +: 8] = lane_0_tx;
        asm1[bpos + 8'd4 +: 8] = lane_1_tx;
      end
      default: begin
        asm0      = '0;
        asm1      = '0;
        asm0[7:0] = lane_0_tx;
        asm1[7:0] = lane_1_tx;
      end
    endcase
    block_start = start && !rst;
  end

  always_ff @(posedge enc_clk) begin
    if (rst) begin
      cnt_q         <= '0;
      hdr_q         <= 1'b0;
      spd_q         <= spd_in;
      buf0_q        <= '0;
      buf1_q        <= '0;
      lane_0_tx_enc <= '0;
      lane_1_tx_enc <= '0;
      enc_valid     <= 1'b0;
    end else begin
      enc_valid <= 1'b0;
      if (!consume) begin
        cnt_q <= '0;
      end else begin
        if (start) begin
          hdr_q <= data_os;
          spd_q <= spd_in;
        end
        if (last) begin
          cnt_q         <= '0;
          lane_0_tx_enc <= asm0;
          lane_1_tx_enc <= asm1;
          enc_valid     <= 1'b1;
        end else begin
          cnt_q  <= idx + 4'd1;
          buf0_q <= asm0;
          buf1_q <= asm1;
        end
      end
    end
  end

endmodule

// File: tb/tb_encoding_block.sv
// tb_encoding_block
//   Directed bench for encoding_block. A queue-based block model is checked
//   against the DUT every cycle, and literal field checks pin the model.
module tb_encoding_block;
  localparam int unsigned BW = 132;

  logic          enc_clk = 1'b0;
  logic          rst;
  logic          enable_enc;
  logic [1:0]    gen_speed;
  logic          data_os;
  logic [7:0]    lane_0_tx;
  logic [7:0]    lane_1_tx;
  logic [BW-1:0] lane_0_tx_enc;
  logic [BW-1:0] lane_1_tx_enc;
  logic          enc_valid;
  logic          block_start;

  int n_assert = 0;
  int n_fail   = 0;
  int n_valid  = 0;
  int n_start  = 0;
  logic bs_seen;
  logic [BW-1:0] held;
  logic [BW-1:0] blk;

  // model state
  logic [7:0]    q0[$];
  logic [7:0]    q1[$];
  logic [1:0]    m_speed;
  logic          m_os;
  logic [BW-1:0] m_exp0;
  logic [BW-1:0] m_exp1;
  logic          m_valid;
  logic          exp_bs;
  logic [BW-1:0] m_hdr;
  int            off;
  bit            armed = 1'b0;

  encoding_block #(.BLOCK_W(BW)) dut (
    .enc_clk      (enc_clk),
    .rst          (rst),
    .enable_enc   (enable_enc),
    .gen_speed    (gen_speed),
    .data_os      (data_os),
    .lane_0_tx    (lane_0_tx),
    .lane_1_tx    (lane_1_tx),
    .lane_0_tx_enc(lane_0_tx_enc),
    .lane_1_tx_enc(lane_1_tx_enc),
    .enc_valid    (enc_valid),
    .block_start  (block_start)
  );

  always #5 enc_clk = ~enc_clk;

  task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int blk_len(input logic [1:0] s);
    case (s)
      2'b10:   return 8;
      2'b01:   return 16;
      default: return 1;
    endcase
  endfunction

  // Compare then step the model at each negedge: the inputs seen here are the
  // ones the next posedge consumes.
  initial forever begin
    @(negedge enc_clk);
    if (armed) begin
      exp_bs = !rst && enable_enc && (gen_speed != 2'b11) &&
               ((q0.size() == 0) || (gen_speed != m_speed));
      chk("enc_valid", BW'(enc_valid), BW'(m_valid));
      chk("lane_0_enc", lane_0_tx_enc, m_exp0);
      chk("lane_1_enc", lane_1_tx_enc, m_exp1);
      chk("block_start", BW'(block_start), BW'(exp_bs));
    end
    if (rst) begin
      q0.delete(); q1.delete();
      m_exp0 = '0; m_exp1 = '0; m_valid = 1'b0; m_os = 1'b0;
      m_speed = gen_speed;
      armed = 1'b1;
    end else if (armed) begin
      m_valid = 1'b0;
      if (!enable_enc || gen_speed == 2'b11) begin
        q0.delete(); q1.delete();
      end else begin
        if (q0.size() == 0 || gen_speed != m_speed) begin
          q0.delete(); q1.delete();
          m_os = data_os;
          m_speed = gen_speed;
        end
        q0.push_back(lane_0_tx);
        q1.push_back(lane_1_tx);
        if (q0.size() == blk_len(m_speed)) begin
          case (m_speed)
            2'b10: begin off = 2; m_hdr = m_os ? BW'(2) : BW'(1); end
            2'b01: begin off = 4; m_hdr = m_os ? BW'(10) : BW'(5); end
            default: begin off = 0; m_hdr = '0; end
          endcase
          m_exp0 = m_hdr;
          m_exp1 = m_hdr;
          foreach (q0[k]) begin
            m_exp0 = m_exp0 | (BW'(q0[k]) << (8 * k + off));
            m_exp1 = m_exp1 | (BW'(q1[k]) << (8 * k + off));
          end
          m_valid = 1'b1;
          q0.delete(); q1.delete();
        end
      end
    end
  end

  task automatic drive(input logic r, input logic en, input logic [1:0] gs,
                       input logic dos, input logic [7:0] b0, input logic [7:0] b1);
    rst = r; enable_enc = en; gen_speed = gs; data_os = dos;
    lane_0_tx = b0; lane_1_tx = b1;
    #1;
    bs_seen = block_start;
    if (bs_seen) n_start++;
    @(posedge enc_clk);
    #1;
    if (enc_valid) n_valid++;
  endtask

  initial begin
    drive(1'b1, 1'b0, 2'b10, 1'b0, 8'h00, 8'h00);
    drive(1'b1, 1'b0, 2'b10, 1'b0, 8'h00, 8'h00);
    chk("rst_valid", BW'(enc_valid), '0);
    chk("rst_lane0", lane_0_tx_enc, '0);
    drive(1'b0, 1'b0, 2'b10, 1'b0, 8'h00, 8'h00);

    // GEN2 data block
    n_valid = 0; n_start = 0;
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 1'b1, 2'b10, 1'b0, 8'(i + 1), 8'(8'h11 + i));
      if (i == 0) chk("gen2_start", BW'(bs_seen), BW'(1));
    end
    chk("gen2_valid", BW'(enc_valid), BW'(1));
    chk("gen2_count", BW'(n_valid), BW'(1));
    chk("gen2_hdr", BW'(lane_0_tx_enc[1:0]), BW'(2'b01));
    chk("gen2_b0", BW'(lane_0_tx_enc[9:2]), BW'(8'h01));
    chk("gen2_b7", BW'(lane_0_tx_enc[65:58]), BW'(8'h08));
    chk("gen2_upper", BW'(lane_0_tx_enc[131:66]), '0);
    chk("gen2_l1_b0", BW'(lane_1_tx_enc[9:2]), BW'(8'h11));
    held = lane_0_tx_enc;
    drive(1'b0, 1'b0, 2'b10, 1'b0, 8'hFF, 8'hFF);
    chk("gen2_idle_valid", BW'(enc_valid), '0);
    chk("gen2_hold", lane_0_tx_enc, held);

    // GEN3 ordered sets, three back-to-back blocks
    n_valid = 0; n_start = 0;
    for (int i = 0; i < 48; i++) begin
      drive(1'b0, 1'b1, 2'b01, 1'(i % 16 == 0), 8'(8'hA0 + i % 16), 8'(8'hB0 + i % 16));
      if (i == 15) blk = lane_0_tx_enc;
    end
    chk("gen3_valids", BW'(n_valid), BW'(3));
    chk("gen3_starts", BW'(n_start), BW'(3));
    chk("gen3_hdr", BW'(blk[3:0]), BW'(4'b1010));
    chk("gen3_b0", BW'(blk[11:4]), BW'(8'hA0));
    chk("gen3_b15", BW'(blk[131:124]), BW'(8'hAF));

    // GEN4 pass-through
    drive(1'b0, 1'b1, 2'b00, 1'b0, 8'h5A, 8'hA5);
    chk("gen4_v0", BW'(enc_valid), BW'(1));
    chk("gen4_b0", lane_0_tx_enc, BW'(8'h5A));
    drive(1'b0, 1'b1, 2'b00, 1'b0, 8'hC3, 8'h3C);
    chk("gen4_v1", BW'(enc_valid), BW'(1));
    chk("gen4_b1", lane_0_tx_enc, BW'(8'hC3));

    // abort on disable
    n_valid = 0;
    for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, 2'b10, 1'b0, 8'(8'h31 + i), 8'h00);
    drive(1'b0, 1'b0, 2'b10, 1'b0, 8'h00, 8'h00);
    drive(1'b0, 1'b0, 2'b10, 1'b0, 8'h00, 8'h00);
    chk("abort_no_valid", BW'(n_valid), '0);
    for (int i = 0; i < 8; i++) drive(1'b0, 1'b1, 2'b10, 1'b0, 8'(8'h21 + i), 8'h00);
    chk("abort_next_valid", BW'(n_valid), BW'(1));
    chk("abort_next_b0", BW'(lane_0_tx_enc[9:2]), BW'(8'h21));
    chk("abort_next_b7", BW'(lane_0_tx_enc[65:58]), BW'(8'h28));

    // speed change mid-block GEN3 -> GEN2
    n_valid = 0;
    for (int i = 0; i < 5; i++) drive(1'b0, 1'b1, 2'b01, 1'b0, 8'(8'h40 + i), 8'h00);
    drive(1'b0, 1'b1, 2'b10, 1'b0, 8'h50, 8'h00);
    chk("spd_switch_start", BW'(bs_seen), BW'(1));
    for (int i = 1; i < 8; i++) drive(1'b0, 1'b1, 2'b10, 1'b0, 8'(8'h50 + i), 8'h00);
    chk("spd_valids", BW'(n_valid), BW'(1));
    chk("spd_hdr", BW'(lane_0_tx_enc[1:0]), BW'(2'b01));
    chk("spd_b0", BW'(lane_0_tx_enc[9:2]), BW'(8'h50));
    chk("spd_upper", BW'(lane_0_tx_enc[131:66]), '0);

    // reset mid-block
    n_valid = 0;
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 2'b10, 1'b0, 8'(8'h60 + i), 8'h00);
    drive(1'b1, 1'b1, 2'b10, 1'b0, 8'h63, 8'h00);
    chk("rst_mid_lane0", lane_0_tx_enc, '0);
    chk("rst_mid_lane1", lane_1_tx_enc, '0);
    chk("rst_mid_valid", BW'(enc_valid), '0);
    for (int i = 4; i < 9; i++) drive(1'b0, 1'b1, 2'b10, 1'b0, 8'(8'h60 + i), 8'h00);
    chk("rst_mid_no_valid", BW'(n_valid), '0);
    drive(1'b0, 1'b0, 2'b10, 1'b0, 8'h00, 8'h00);

    // header sampled only on byte 0
    for (int i = 0; i < 8; i++) drive(1'b0, 1'b1, 2'b10, 1'(i % 2), 8'(8'h70 + i), 8'h00);
    chk("hdr_valid", BW'(enc_valid), BW'(1));
    chk("hdr_kept", BW'(lane_0_tx_enc[1:0]), BW'(2'b01));

    // reserved speed consumes nothing
    n_valid = 0; n_start = 0;
    for (int i = 0; i < 10; i++) drive(1'b0, 1'b1, 2'b11, 1'b0, 8'(i), 8'(i));
    chk("rsvd_valids", BW'(n_valid), '0);
    chk("rsvd_starts", BW'(n_start), '0);
    drive(1'b0, 1'b0, 2'b10, 1'b0, 8'h00, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
